// File: rtl/qoa_cmd_sequencer.sv
// SPI command sequencer for the QOA decoder: parses opcode frames into 16-bit
// decoder load words, issues slice starts, and buffers decoded samples for readback.
module qoa_cmd_sequencer #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        sclk,
  input  logic        rst_n,
  input  logic        cs_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        dec_ready,
  output logic        dec_load,
  output logic [1:0]  dec_sel,
  output logic [1:0]  dec_idx,
  output logic [15:0] dec_word,
  output logic        dec_start,
  input  logic        sample_valid,
  input  logic [15:0] sample,
  output logic        sample_ready,
  output logic [15:0] tx_word,
  output logic        busy,
  output logic [2:0]  err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, PAYLOAD, PEND, START} state_t;

  state_t        state;
  logic [2:0]    cnt;
  logic [7:0]    hi_byte;
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;

  logic cmd, read_cmd, clr_cmd, empty, push, pop;
  logic ev_abort, ev_over, ev_under;

  always_comb begin
    cmd          = rx_valid && (state == IDLE);
    read_cmd     = cmd && (rx_byte == 8'h04);
    clr_cmd      = cmd && (rx_byte == 8'h0F);
    empty        = (count == '0);
    sample_ready = (count != CW'(FIFO_DEPTH));
    push         = sample_valid && sample_ready;
    pop          = read_cmd && !empty;
    ev_under     = read_cmd && empty;
    ev_over      = rx_valid && (state == PEND);
    ev_abort     = cs_n && (((state == PAYLOAD) && (cnt != '0)) || (state == PEND));
  end

  assign busy = (state != IDLE);

  always_ff @(posedge sclk) begin
    if (push) mem[wptr] <= sample;
  end

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      hi_byte   <= '0;
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      tx_word   <= '0;
      err       <= '0;
      dec_load  <= 1'b0;
      dec_start <= 1'b0;
      dec_word  <= '0;
      dec_sel   <= '0;
      dec_idx   <= '0;
    end else begin
      // New error events win over a same-cycle CLR_ERR.
      err <= (clr_cmd ? 3'b000 : err) | {ev_abort, ev_over, ev_under};

      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        tx_word <= mem[rptr];
        rptr    <= rptr + 1'b1;
      end else if (ev_under) begin
        tx_word <= 16'h8000;
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;

      case (state)
        IDLE: begin
          dec_start <= 1'b0;
          if (rx_valid && (rx_byte == 8'h01 || rx_byte == 8'h02 || rx_byte == 8'h03)) begin
            state   <= PAYLOAD;
            cnt     <= '0;
            dec_sel <= rx_byte[1:0] - 2'd1;
          end
        end
        PAYLOAD: begin
          if (cs_n) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (rx_valid) begin
            cnt <= cnt + 3'd1;
            if (!cnt[0]) begin
              hi_byte <= rx_byte;
            end else begin
              dec_word <= {hi_byte, rx_byte};
              dec_idx  <= cnt[2:1];
              dec_load <= 1'b1;
              state    <= PEND;
            end
          end
        end
        PEND: begin
          if (cs_n) begin
            state    <= IDLE;
            cnt      <= '0;
            dec_load <= 1'b0;
          end else if (dec_ready) begin
            dec_load <= 1'b0;
            if (dec_idx != 2'd3) begin
              state <= PAYLOAD;
            end else if (dec_sel == 2'd2) begin
              state     <= START;
              dec_start <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        START: begin
          dec_start <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qoa_cmd_sequencer.sv
// Self-checking bench for qoa_cmd_sequencer: load words and readback words are
// queued as expectations when stimulus is driven and compared as the DUT produces them.
module tb_qoa_cmd_sequencer;

  logic        sclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = '0;
  logic        dec_ready = 1'b0;
  logic        dec_load;
  logic [1:0]  dec_sel;
  logic [1:0]  dec_idx;
  logic [15:0] dec_word;
  logic        dec_start;
  logic        sample_valid = 1'b0;
  logic [15:0] sample = '0;
  logic        sample_ready;
  logic [15:0] tx_word;
  logic        busy;
  logic [2:0]  err;

  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned start_cnt = 0;
  logic [19:0] loadq[$];
  logic [15:0] txq[$];

  qoa_cmd_sequencer #(.FIFO_DEPTH(4)) dut (
    .sclk(sclk), .rst_n(rst_n), .cs_n(cs_n), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .dec_ready(dec_ready), .dec_load(dec_load), .dec_sel(dec_sel), .dec_idx(dec_idx),
    .dec_word(dec_word), .dec_start(dec_start), .sample_valid(sample_valid),
    .sample(sample), .sample_ready(sample_ready), .tx_word(tx_word), .busy(busy), .err(err)
  );

  always #5 sclk = ~sclk;

  // Load scoreboard consumer and start-pulse counter.
  always @(negedge sclk) begin
    if (dec_start) start_cnt++;
    if (dec_load && dec_ready) begin
      logic [19:0] exp_l;
      checks++;
      if (loadq.size() == 0) begin
        $display("FAIL load_unexpected got=%h", {dec_sel, dec_idx, dec_word});
      end else begin
        exp_l = loadq.pop_front();
        if ({dec_sel, dec_idx, dec_word} !== exp_l)
          $display("FAIL load got=%h exp=%h", {dec_sel, dec_idx, dec_word}, exp_l);
        else passed++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge sclk); #1 rx_valid = 1'b1; rx_byte = b;
    @(posedge sclk); #1 rx_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    send_byte(b);
    repeat (3) @(posedge sclk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 60) begin @(negedge sclk); n++; end
    checks++;
    if (busy) $display("FAIL %s_idle_timeout busy=%b exp=0", name, busy);
    else passed++;
  endtask

  task automatic check_err(input string name, input logic [2:0] e);
    @(negedge sclk);
    checks++;
    if (err !== e) $display("FAIL %s err=%b exp=%b", name, err, e);
    else passed++;
  endtask

  task automatic check_loads_done(input string name);
    checks++;
    if (loadq.size() != 0) $display("FAIL %s loads_pending=%0d exp=0", name, loadq.size());
    else passed++;
  endtask

  task automatic check_reset_vals(input string name);
    @(negedge sclk);
    checks++;
    if ({busy, dec_load, dec_start, dec_sel, dec_idx, dec_word, tx_word, err, sample_ready} !==
        {1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 16'h0000, 16'h0000, 3'b000, 1'b1})
      $display("FAIL %s got busy=%b load=%b start=%b sel=%0d idx=%0d word=%h tx=%h err=%b rdy=%b exp all zero, rdy=1",
               name, busy, dec_load, dec_start, dec_sel, dec_idx, dec_word, tx_word, err, sample_ready);
    else passed++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge sclk);
    #1 check_reset_vals("reset");
    #1 rst_n = 1'b1;
    @(posedge sclk); #1;
    check_reset_vals("after_reset_release");
  endtask

  task automatic test_load_weights;
    logic [7:0] fr [9] = '{8'h02, 8'h00, 8'h10, 8'hFF, 8'hF0, 8'h12, 8'h34, 8'h80, 8'h00};
    dec_ready = 1'b1;
    loadq.push_back({2'd1, 2'd0, 16'h0010});
    loadq.push_back({2'd1, 2'd1, 16'hFFF0});
    loadq.push_back({2'd1, 2'd2, 16'h1234});
    loadq.push_back({2'd1, 2'd3, 16'h8000});
    for (int i = 0; i < 9; i++) send_gap(fr[i]);
    wait_idle("load_weights");
    check_loads_done("load_weights");
    check_err("load_weights", 3'b000);
  endtask

  task automatic test_decode_stall;
    int unsigned s0 = start_cnt;
    dec_ready = 1'b1;
    loadq.push_back({2'd2, 2'd0, 16'h1122});
    loadq.push_back({2'd2, 2'd1, 16'h3344});
    loadq.push_back({2'd2, 2'd2, 16'h5566});
    loadq.push_back({2'd2, 2'd3, 16'h7788});
    send_gap(8'h03);
    send_gap(8'h11); send_gap(8'h22); send_gap(8'h33); send_gap(8'h44); send_gap(8'h55);
    dec_ready = 1'b0;
    send_byte(8'h66);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) send_byte(8'hAA);
      @(negedge sclk);
      checks++;
      if ({dec_load, dec_idx, dec_word} !== {1'b1, 2'd2, 16'h5566})
        $display("FAIL stall_hold cyc=%0d load=%b idx=%0d word=%h exp load=1 idx=2 word=5566",
                 c, dec_load, dec_idx, dec_word);
      else passed++;
    end
    check_err("stall_overrun", 3'b010);
    @(posedge sclk); #1 dec_ready = 1'b1;
    repeat (2) @(posedge sclk);
    #1;
    send_gap(8'h77);
    send_byte(8'h88);
    wait_idle("decode_slice");
    repeat (3) @(negedge sclk);
    checks++;
    if (start_cnt - s0 != 1) $display("FAIL start_pulses got=%0d exp=1", start_cnt - s0);
    else passed++;
    check_loads_done("decode_slice");
    check_err("decode_err_sticky", 3'b010);
    send_gap(8'h0F);
    check_err("clr_after_decode", 3'b000);
  endtask

  task automatic test_fifo;
    for (int i = 1; i <= 5; i++) begin
      @(posedge sclk); #1 sample_valid = 1'b1; sample = 16'(i);
      @(negedge sclk);
      checks++;
      if (sample_ready !== (i <= 4))
        $display("FAIL sample_ready n=%0d got=%b exp=%b", i, sample_ready, (i <= 4));
      else passed++;
      @(posedge sclk); #1 sample_valid = 1'b0;
    end
    for (int i = 1; i <= 5; i++) begin
      logic [15:0] exp_t;
      txq.push_back(i <= 4 ? 16'(i) : 16'h8000);
      send_byte(8'h04);
      exp_t = txq.pop_front();
      checks++;
      if (tx_word !== exp_t) $display("FAIL read n=%0d tx=%h exp=%h", i, tx_word, exp_t);
      else passed++;
    end
    check_err("underflow", 3'b001);
    send_gap(8'h0F);
    check_err("clr_after_underflow", 3'b000);
  endtask

  task automatic test_abort;
    dec_ready = 1'b1;
    loadq.push_back({2'd0, 2'd0, 16'hA1B2});
    send_gap(8'h01); send_gap(8'hA1); send_gap(8'hB2); send_gap(8'hC3);
    @(posedge sclk); #1 cs_n = 1'b1;
    @(posedge sclk); #1;
    @(negedge sclk);
    checks++;
    if (busy !== 1'b0) $display("FAIL abort_state busy=%b exp=0", busy);
    else passed++;
    check_err("abort", 3'b100);
    #1 cs_n = 1'b0;
    repeat (3) @(posedge sclk);
    #1 check_loads_done("abort");
    send_gap(8'h0F);
    check_err("clr_after_abort", 3'b000);
  endtask

  task automatic test_reset_midframe;
    int unsigned s0 = start_cnt;
    dec_ready = 1'b1;
    loadq.push_back({2'd0, 2'd0, 16'h1020});
    loadq.push_back({2'd0, 2'd1, 16'h3040});
    send_gap(8'h01);
    send_gap(8'h10); send_gap(8'h20); send_gap(8'h30); send_gap(8'h40); send_gap(8'h50);
    @(posedge sclk); #1 rst_n = 1'b0;
    @(posedge sclk); #1 rst_n = 1'b1;
    check_reset_vals("midframe_reset");
    check_loads_done("pre_reset_loads");
    loadq.push_back({2'd0, 2'd0, 16'h0102});
    loadq.push_back({2'd0, 2'd1, 16'h0304});
    loadq.push_back({2'd0, 2'd2, 16'h0506});
    loadq.push_back({2'd0, 2'd3, 16'h0708});
    send_gap(8'h01);
    for (int i = 1; i <= 8; i++) send_gap(8'(i));
    wait_idle("post_reset_frame");
    repeat (3) @(posedge sclk);
    #1 check_loads_done("post_reset_frame");
    checks++;
    if (start_cnt != s0) $display("FAIL no_start_for_hist got=%0d exp=%0d", start_cnt, s0);
    else passed++;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load_weights();
    test_decode_stall();
    test_fifo();
    test_abort();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
